impact_detector: RTL and testbench

//  Per-pixel collision detector that feeds the forcefield's impact input and the ship/bullet logic.

---
 rtl/impact_detector_if.sv | 37 +++
 rtl/impact_detector.sv | 116 +++++++++++
 tb/tb_impact_detector.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/impact_detector_if.sv
// Bus bundle for impact_detector: per-pixel drawing flags in, per-frame collision results out.
// Ports (slave side): frame, ff_drawing, ship_drawing, bullet_drawing in;
//   impact, ship_hit, bullet_kill, invulnerable out (+ hit_count when IMPACT_HITCNT_EN is defined).
interface impact_detector_if #(
   parameter int N_BULLETS = 4,
   parameter int HITCNT_W  = 8
);
   logic                 frame;
   logic                 ff_drawing;
   logic                 ship_drawing;
   logic [N_BULLETS-1:0] bullet_drawing;
   logic                 impact;
   logic                 ship_hit;
   logic [N_BULLETS-1:0] bullet_kill;
   logic                 invulnerable;
`ifdef IMPACT_HITCNT_EN
   logic [HITCNT_W-1:0]  hit_count;
`endif

   // Stimulus side: drives the pixel flags, observes the results.
   modport master (
      output frame, ff_drawing, ship_drawing, bullet_drawing,
      input  impact, ship_hit, bullet_kill, invulnerable
`ifdef IMPACT_HITCNT_EN
      , input hit_count
`endif
   );

   // Detector side.
   modport slave (
      input  frame, ff_drawing, ship_drawing, bullet_drawing,
      output impact, ship_hit, bullet_kill, invulnerable
`ifdef IMPACT_HITCNT_EN
      , output hit_count
`endif
   );
endinterface

// File: rtl/impact_detector.sv
// Per-pixel collision detector: accumulates bullet/forcefield and bullet/ship overlaps over a
// frame and publishes impact, ship_hit, bullet_kill and invulnerable at the next frame pulse.
// Ports: clk, rst (sync, active-high), bus (impact_detector_if.slave). Optional macro
// IMPACT_HITCNT_EN adds a saturating hit_count output on the bus. Outputs valid the cycle after
// a frame pulse and held for the whole following frame; no backpressure.
module impact_detector #(
   parameter int N_BULLETS    = 4,
   parameter int GRACE_FRAMES = 90,
   parameter int HITCNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   impact_detector_if.slave   bus
);

   // Counter width clog2(GRACE_FRAMES+1); kept at least 1 bit so GRACE_FRAMES=0 still elaborates.
   localparam int GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t               state_q;
   logic [N_BULLETS-1:0] acc_ff_q;
   logic [N_BULLETS-1:0] acc_ship_q;
   logic [GW-1:0]        grace_q;
   logic                 impact_q;
   logic                 ship_hit_q;
   logic [N_BULLETS-1:0] bullet_kill_q;
   logic                 invulnerable_q;

   // Overlaps on the current pixel. A ship overlap under the forcefield is absorbed by the shield.
   logic [N_BULLETS-1:0] ovl_ff;
   logic [N_BULLETS-1:0] ovl_ship;
   // Values published at a frame pulse, derived from the frame now ending.
   logic                 ship_hit_d;
   logic [GW-1:0]        grace_d;

   always_comb begin
      ovl_ff   = bus.bullet_drawing & {N_BULLETS{bus.ff_drawing}};
      ovl_ship = bus.bullet_drawing & {N_BULLETS{bus.ship_drawing & ~bus.ff_drawing}};

      // A bullet that touched the forcefield anywhere in the frame cannot also hit the ship.
      ship_hit_d = (|(acc_ship_q & ~acc_ff_q)) && (grace_q == '0);

      grace_d = grace_q;
      if (ship_hit_d) begin
         grace_d = GW'(GRACE_FRAMES);
      end else if (grace_q != '0) begin
         grace_d = grace_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_WAIT;
         acc_ff_q       <= '0;
         acc_ship_q     <= '0;
         grace_q        <= '0;
         impact_q       <= 1'b0;
         ship_hit_q     <= 1'b0;
         bullet_kill_q  <= '0;
         invulnerable_q <= 1'b0;
      end else begin
         case (state_q)
            ST_WAIT: begin
               // Partial frame: nothing accumulated so far is trusted. Overlaps on the frame
               // cycle itself already belong to the first full frame.
               if (bus.frame) begin
                  state_q    <= ST_SCAN;
                  acc_ff_q   <= ovl_ff;
                  acc_ship_q <= ovl_ship;
               end
            end
            ST_SCAN: begin
               if (bus.frame) begin
                  impact_q       <= |acc_ff_q;
                  ship_hit_q     <= ship_hit_d;
                  bullet_kill_q  <= acc_ff_q | acc_ship_q;
                  grace_q        <= grace_d;
                  invulnerable_q <= (grace_d != '0);
                  // Clear-then-set: the frame-cycle pixel starts the new frame.
                  acc_ff_q       <= ovl_ff;
                  acc_ship_q     <= ovl_ship;
               end else begin
                  acc_ff_q   <= acc_ff_q | ovl_ff;
                  acc_ship_q <= acc_ship_q | ovl_ship;
               end
            end
            default: state_q <= ST_WAIT;
         endcase
      end
   end

   assign bus.impact       = impact_q;
   assign bus.ship_hit     = ship_hit_q;
   assign bus.bullet_kill  = bullet_kill_q;
   assign bus.invulnerable = invulnerable_q;

`ifdef IMPACT_HITCNT_EN
   logic [HITCNT_W-1:0] hit_count_q;

   // Counts published ship hits, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count_q <= '0;
      end else if (state_q == ST_SCAN && bus.frame && ship_hit_d && hit_count_q != '1) begin
         hit_count_q <= hit_count_q + 1'b1;
      end
   end

   assign bus.hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_impact_detector.sv
// Directed bench for impact_detector: a per-frame vector table plus hand-written corner sequences.
// Three instances share stimulus: default grace (90), grace 3, grace 0 with a 2-bit hit counter.
// Inputs change on the falling edge; outputs are compared on the falling edge after a frame pulse.
module tb_impact_detector;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   impact_detector_if #(.N_BULLETS(4), .HITCNT_W(8)) if_a ();
   impact_detector_if #(.N_BULLETS(4), .HITCNT_W(8)) if_b ();
   impact_detector_if #(.N_BULLETS(4), .HITCNT_W(2)) if_c ();

   impact_detector #(.N_BULLETS(4), .GRACE_FRAMES(90), .HITCNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .bus(if_a.slave));
   impact_detector #(.N_BULLETS(4), .GRACE_FRAMES(3), .HITCNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .bus(if_b.slave));
   impact_detector #(.N_BULLETS(4), .GRACE_FRAMES(0), .HITCNT_W(2)) dut_c (
      .clk(clk), .rst(rst), .bus(if_c.slave));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic f, input logic ff, input logic ship, input logic [3:0] bul);
      if_a.frame = f; if_a.ff_drawing = ff; if_a.ship_drawing = ship; if_a.bullet_drawing = bul;
      if_b.frame = f; if_b.ff_drawing = ff; if_b.ship_drawing = ship; if_b.bullet_drawing = bul;
      if_c.frame = f; if_c.ff_drawing = ff; if_c.ship_drawing = ship; if_c.bullet_drawing = bul;
   endtask

   // Holds the given inputs for n rising edges, then returns all inputs to idle.
   task automatic drive(input logic f, input logic ff, input logic ship, input logic [3:0] bul,
                        input int n);
      set_in(f, ff, ship, bul);
      repeat (n) @(negedge clk);
      set_in(1'b0, 1'b0, 1'b0, 4'b0000);
   endtask

   task automatic frame_pulse();
      drive(1'b1, 1'b0, 1'b0, 4'b0000, 1);
   endtask

   task automatic do_reset();
      set_in(1'b0, 1'b0, 1'b0, 4'b0000);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One frame of stimulus (two pixel phases) and what dut_a / dut_c publish at the closing pulse.
   typedef struct {
      logic       a_ff, a_ship; logic [3:0] a_bul; int a_n;
      logic       b_ff, b_ship; logic [3:0] b_bul; int b_n;
      logic       e_imp, e_hit;  logic [3:0] e_kill; logic e_inv;
      logic       e_hit_c;
   } vec_t;

   vec_t tbl[7];
   int   exp_b_hit[5];
   int   exp_cnt[5];

   initial begin
      // ff overlap by bullet 0 on one pixel
      tbl[0] = '{1,0,4'b0001,1,  0,0,4'b0000,0,  1,0,4'b0001,0, 0};
      // empty frame: results fall back to 0
      tbl[1] = '{0,0,4'b0000,0,  0,0,4'b0000,0,  0,0,4'b0000,0, 0};
      // bullet 2 on ship for 50 pixels: hit, grace starts
      tbl[2] = '{0,1,4'b0100,50, 0,0,4'b0000,0,  0,1,4'b0100,1, 1};
      // bullet 1 on ff one pixel, on ship another: shield wins
      tbl[3] = '{1,0,4'b0010,1,  0,1,4'b0010,1,  1,0,4'b0010,1, 0};
      // bullets 0 and 3 on ship: dut_a in grace (kills only), dut_c hits once
      tbl[4] = '{0,1,4'b1001,2,  0,0,4'b0000,0,  0,0,4'b1001,1, 1};
      // bullet 3 on ff and ship on the same pixel: shield absorbs it
      tbl[5] = '{1,1,4'b1000,3,  0,0,4'b0000,0,  1,0,4'b1000,1, 0};
      // ff and ship drawn with no bullet: nothing
      tbl[6] = '{1,1,4'b0000,4,  0,0,4'b0000,0,  0,0,4'b0000,1, 0};
      exp_b_hit = '{1, 0, 0, 0, 1};
      exp_cnt   = '{1, 2, 3, 3, 3};

      set_in(1'b0, 1'b0, 1'b0, 4'b0000);
      @(negedge clk);
      do_reset();

      check("rst_impact",   if_a.impact,       0);
      check("rst_ship_hit", if_a.ship_hit,     0);
      check("rst_kill",     if_a.bullet_kill,  0);
      check("rst_invuln",   if_a.invulnerable, 0);
`ifdef IMPACT_HITCNT_EN
      check("rst_hitcnt",   if_c.hit_count,    0);
`endif

      // WAIT state ignores pixels and publishes nothing on its frame pulse.
      drive(1'b0, 1'b1, 1'b0, 4'b1111, 3);
      frame_pulse();
      check("wait_frame_impact", if_a.impact, 0);
      check("wait_frame_kill",   if_a.bullet_kill, 0);

      for (int i = 0; i < 7; i++) begin
         if (tbl[i].a_n > 0) drive(1'b0, tbl[i].a_ff, tbl[i].a_ship, tbl[i].a_bul, tbl[i].a_n);
         if (tbl[i].b_n > 0) drive(1'b0, tbl[i].b_ff, tbl[i].b_ship, tbl[i].b_bul, tbl[i].b_n);
         @(negedge clk);
         frame_pulse();
         check($sformatf("v%0d_impact", i),   if_a.impact,       tbl[i].e_imp);
         check($sformatf("v%0d_ship_hit", i), if_a.ship_hit,     tbl[i].e_hit);
         check($sformatf("v%0d_kill", i),     if_a.bullet_kill,  tbl[i].e_kill);
         check($sformatf("v%0d_invuln", i),   if_a.invulnerable, tbl[i].e_inv);
         check($sformatf("v%0d_hit_g0", i),   if_c.ship_hit,     tbl[i].e_hit_c);
         check($sformatf("v%0d_inv_g0", i),   if_c.invulnerable, 0);
      end

      // Overlap on the frame cycle itself lands in the following publish, not this one.
      drive(1'b1, 1'b1, 1'b0, 4'b0001, 1);
      check("fcyc_now_impact", if_a.impact, 0);
      check("fcyc_now_kill",   if_a.bullet_kill, 0);
      repeat (5) @(negedge clk);
      frame_pulse();
      check("fcyc_next_impact", if_a.impact, 1);
      check("fcyc_next_kill",   if_a.bullet_kill, 4'b0001);
      repeat (20) @(negedge clk);
      check("hold_impact", if_a.impact, 1);
      check("hold_kill",   if_a.bullet_kill, 4'b0001);

      // Reset mid-frame: pending overlaps dropped, next frame in WAIT discarded.
      drive(1'b0, 1'b1, 1'b0, 4'b0100, 2);
      do_reset();
      check("mid_rst_impact", if_a.impact, 0);
      check("mid_rst_kill",   if_a.bullet_kill, 0);
      drive(1'b0, 1'b1, 1'b0, 4'b0100, 2);
      frame_pulse();
      check("mid_rst_wait_impact", if_a.impact, 0);
      frame_pulse();
      check("mid_rst_scan_impact", if_a.impact, 0);
      check("mid_rst_scan_kill",   if_a.bullet_kill, 0);

      // Frame in WAIT coinciding with an overlap: counted in the first SCAN frame.
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 4'b0010, 1);
      check("wait_ovl_now", if_a.impact, 0);
      repeat (3) @(negedge clk);
      frame_pulse();
      check("wait_ovl_impact", if_a.impact, 1);
      check("wait_ovl_kill",   if_a.bullet_kill, 4'b0010);

      // Grace of 3 frames, ship hit every frame; hit counter saturation on the grace-0 instance.
      do_reset();
      frame_pulse();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 1'b1, 4'b0001, 3);
         @(negedge clk);
         frame_pulse();
         check($sformatf("g3_f%0d_hit", k),  if_b.ship_hit, exp_b_hit[k]);
         check($sformatf("g3_f%0d_kill", k), if_b.bullet_kill, 4'b0001);
         check($sformatf("g3_f%0d_inv", k),  if_b.invulnerable, (k < 3 || k == 4) ? 1 : 0);
         check($sformatf("g0_f%0d_hit", k),  if_c.ship_hit, 1);
`ifdef IMPACT_HITCNT_EN
         check($sformatf("cnt_f%0d", k),     if_c.hit_count, exp_cnt[k]);
`endif
      end
      do_reset();
      check("end_rst_hit", if_b.ship_hit, 0);
      check("end_rst_inv", if_b.invulnerable, 0);
`ifdef IMPACT_HITCNT_EN
      check("end_rst_cnt", if_c.hit_count, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
